// File: rtl/mem_stage_ctrl_if.sv
// Upstream/downstream bus of the memory stage: execute-side op inputs, stall back-pressure
// and the registered completion outputs towards writeback.
//
// Handshake: an op transfers on a rising edge where in_valid = 1 and stall = 0; while stall = 1
// the master holds every op field stable. out_valid is a one-cycle pulse per completed op, and
// load_data/misalign are meaningful only while out_valid = 1.
interface mem_stage_ctrl_if;
    logic        in_valid;
    logic [31:0] mResult;
    logic [31:0] mAddr;
    logic        mRdEnable;
    logic        mAddrEnable;
    logic [1:0]  mSize;
    logic        mUnsigned;
    logic        stall;
    logic        out_valid;
    logic [31:0] load_data;
    logic        misalign;

    modport master (
        output in_valid, mResult, mAddr, mRdEnable, mAddrEnable, mSize, mUnsigned,
        input  stall, out_valid, load_data, misalign
    );

    modport slave (
        input  in_valid, mResult, mAddr, mRdEnable, mAddrEnable, mSize, mUnsigned,
        output stall, out_valid, load_data, misalign
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage: word RAM with byte-enable stores, sized/extended loads with a configurable
// read latency (1..3), pass-through of non-memory results, and stall while a load waits.
// An op accepted on the last wait cycle of a load completes one cycle behind that load
// through a one-entry skid register, so completions always leave in accept order.
module mem_stage_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_stage_ctrl_if.slave   bus,
    output logic              dbg_state_o
);
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rd_pipe_q [RD_LATENCY];

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [1:0]  a_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        out_valid_q, misalign_q;
    logic [31:0] load_data_q;
    logic        skid_v_q, skid_mis_q;
    logic [31:0] skid_data_q;

    logic              accept_c, is_load_c, is_store_c, misal_c;
    logic              last_c, stall_c, ld_done_c, start_load_c;
    logic              wr_en_c, rd_en_c;
    logic [ADDR_W-1:0] widx_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c, rd_word_c, ld_res_c;
    logic [7:0]        lane_b_c;
    logic [15:0]       lane_h_c;
    logic              new_v_c, new_mis_c;
    logic [31:0]       new_data_c;
    logic              first_v_c, first_mis_c, second_v_c;
    logic [31:0]       first_data_c;
    logic              unused_addr;

    assign unused_addr = ^bus.mAddr[31:ADDR_W+2];

    // Op decode, misalignment, stall and store lane/data formatting
    always_comb begin
        last_c       = (cnt_q == 2'(RD_LATENCY - 1));
        stall_c      = (state_q == S_WAIT) && !last_c;
        ld_done_c    = (state_q == S_WAIT) && last_c;
        accept_c     = bus.in_valid && !stall_c;
        is_load_c    = bus.mAddrEnable && bus.mRdEnable;
        is_store_c   = bus.mAddrEnable && !bus.mRdEnable;
        misal_c      = ((bus.mSize == 2'b01) && bus.mAddr[0]) ||
                       (bus.mSize[1] && (bus.mAddr[1:0] != 2'b00));
        start_load_c = accept_c && is_load_c && !misal_c;
        wr_en_c      = accept_c && is_store_c && !misal_c;
        rd_en_c      = start_load_c;
        widx_c       = bus.mAddr[ADDR_W+1:2];
        case (bus.mSize)
            2'b00:   begin be_c = 4'b0001 << bus.mAddr[1:0]; wdata_c = {4{bus.mResult[7:0]}};  end
            2'b01:   begin be_c = bus.mAddr[1] ? 4'b1100 : 4'b0011; wdata_c = {2{bus.mResult[15:0]}}; end
            default: begin be_c = 4'b1111; wdata_c = bus.mResult; end
        endcase
        // Non-load completions: pass, store, or a misaligned load that returns zero
        new_v_c    = accept_c && !start_load_c;
        new_data_c = is_load_c ? 32'h0 : bus.mResult;
        new_mis_c  = bus.mAddrEnable && misal_c;
    end

    // Lane select and extension of the word arriving on the last wait cycle
    always_comb begin
        rd_word_c = rd_pipe_q[RD_LATENCY-1];
        case (a_q)
            2'd0:    lane_b_c = rd_word_c[7:0];
            2'd1:    lane_b_c = rd_word_c[15:8];
            2'd2:    lane_b_c = rd_word_c[23:16];
            default: lane_b_c = rd_word_c[31:24];
        endcase
        lane_h_c = a_q[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        case (size_q)
            2'b00:   ld_res_c = uns_q ? {24'h0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
            2'b01:   ld_res_c = uns_q ? {16'h0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
            default: ld_res_c = rd_word_c;
        endcase
    end

    // Completion ordering: skid (oldest) or load result first, a same-edge new op second
    always_comb begin
        first_v_c    = 1'b0;
        first_data_c = 32'h0;
        first_mis_c  = 1'b0;
        second_v_c   = 1'b0;
        if (skid_v_q) begin
            first_v_c    = 1'b1;
            first_data_c = skid_data_q;
            first_mis_c  = skid_mis_q;
            second_v_c   = new_v_c;
        end else if (ld_done_c) begin
            first_v_c    = 1'b1;
            first_data_c = ld_res_c;
            second_v_c   = new_v_c;
        end else if (new_v_c) begin
            first_v_c    = 1'b1;
            first_data_c = new_data_c;
            first_mis_c  = new_mis_c;
        end
    end

    // RAM: byte-lane write at the accept edge, read launched at load accept then delayed
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem_q[widx_c][8*i +: 8] <= wdata_c[8*i +: 8];
            end
        end
        if (rd_en_c) rd_pipe_q[0] <= mem_q[widx_c];
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end

    // Load FSM, latency counter and registered completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            a_q         <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            out_valid_q <= 1'b0;
            load_data_q <= 32'h0;
            misalign_q  <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= 32'h0;
            skid_mis_q  <= 1'b0;
        end else begin
            out_valid_q <= first_v_c;
            if (first_v_c) begin
                load_data_q <= first_data_c;
                misalign_q  <= first_mis_c;
            end
            skid_v_q <= second_v_c;
            if (second_v_c) begin
                skid_data_q <= new_data_c;
                skid_mis_q  <= new_mis_c;
            end
            if (start_load_c) begin
                state_q <= S_WAIT;
                cnt_q   <= 2'd0;
                a_q     <= bus.mAddr[1:0];
                size_q  <= bus.mSize;
                uns_q   <= bus.mUnsigned;
            end else if (state_q == S_WAIT) begin
                if (last_c) state_q <= S_IDLE;
                else        cnt_q   <= cnt_q + 2'd1;
            end
        end
    end

    assign bus.stall     = stall_c;
    assign bus.out_valid = out_valid_q;
    assign bus.load_data = load_data_q;
    assign bus.misalign  = misalign_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed steps then random ops against a byte-array memory model.
module tb_mem_stage_ctrl;
    localparam int AW    = 6;
    localparam int DEPTH = 2**AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    logic dbg_state, dbg_state3;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  ref_mem [4*DEPTH];
    logic [32:0] exp_q [$];
    logic [32:0] sb_e;

    mem_stage_ctrl_if bus ();
    mem_stage_ctrl_if bus3 ();

    mem_stage_ctrl #(.ADDR_W(AW), .RD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state_o(dbg_state)
    );
    mem_stage_ctrl #(.ADDR_W(AW), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3.slave), .dbg_state_o(dbg_state3)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, address wraps modulo the RAM size
    task automatic model_op(input logic [31:0] res, input logic [31:0] addr, input logic rd,
                            input logic ae, input logic [1:0] sz, input logic uns,
                            output logic [32:0] e);
        int n;
        int base;
        logic mis;
        logic [31:0] v;
        if (!ae) begin
            e = {1'b0, res};
            return;
        end
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis  = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        base = int'(addr % (4 * DEPTH));
        if (!rd) begin
            if (!mis) for (int k = 0; k < n; k++) ref_mem[base+k] = res[8*k +: 8];
            e = {mis, res};
        end else if (mis) begin
            e = {1'b1, 32'h0};
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[base+k];
            if (n < 4 && !uns && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
            e = {1'b0, v};
        end
    endtask

    // Driver: present an op, hold it through stall, record the expected completion
    task automatic issue(input logic [31:0] res, input logic [31:0] addr, input logic rd,
                         input logic ae, input logic [1:0] sz, input logic uns);
        int budget;
        logic [32:0] e;
        bus.mResult     = res;
        bus.mAddr       = addr;
        bus.mRdEnable   = rd;
        bus.mAddrEnable = ae;
        bus.mSize       = sz;
        bus.mUnsigned   = uns;
        bus.in_valid    = 1'b1;
        budget = 16;
        while (bus.stall !== 1'b0 && budget > 0) begin
            step();
            budget--;
        end
        check("accept_stall", {31'b0, bus.stall}, 32'd0);
        model_op(res, addr, rd, ae, sz, uns, e);
        exp_q.push_back(e);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] d, input logic m);
        int budget;
        budget = 8;
        while (bus.out_valid !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        check({tag, "_data"}, bus.load_data, d);
        check({tag, "_mis"}, {31'b0, bus.misalign}, {31'b0, m});
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=out_valid expected=idle");
            end
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                check("sb_data", bus.load_data, sb_e[31:0]);
                check("sb_mis", {31'b0, bus.misalign}, {31'b0, sb_e[32]});
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        int          kind;
        int          budget;

        bus.in_valid = 1'b0; bus.mResult = 32'h0; bus.mAddr = 32'h0; bus.mRdEnable = 1'b0;
        bus.mAddrEnable = 1'b0; bus.mSize = 2'b00; bus.mUnsigned = 1'b0;
        bus3.in_valid = 1'b0; bus3.mResult = 32'h0; bus3.mAddr = 32'h0; bus3.mRdEnable = 1'b0;
        bus3.mAddrEnable = 1'b0; bus3.mSize = 2'b00; bus3.mUnsigned = 1'b0;

        // Reset values
        step();
        step();
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_load_data", bus.load_data, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'd0);
        check("rst_state", {31'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        rst3 = 1'b0;
        step();
        check("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);

        // Pass-through, latency 1
        issue(32'h1234_5678, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("t1_no_stall", {31'b0, bus.stall}, 32'd0);
        wait_result("t1_pass", 32'h1234_5678, 1'b0);

        // Word store then word load (read latency 2)
        issue(32'hDEAD_BEEF, 32'h40, 1'b0, 1'b1, 2'b10, 1'b0);
        wait_result("t2_store", 32'hDEAD_BEEF, 1'b0);
        issue(32'h0, 32'h40, 1'b1, 1'b1, 2'b10, 1'b0);
        check("t2_stall_c1", {31'b0, bus.stall}, 32'd1);
        check("t2_valid_c1", {31'b0, bus.out_valid}, 32'd0);
        step();
        check("t2_stall_c2", {31'b0, bus.stall}, 32'd0);
        check("t2_valid_c2", {31'b0, bus.out_valid}, 32'd0);
        step();
        check("t2_valid_c3", {31'b0, bus.out_valid}, 32'd1);
        check("t2_data_c3", bus.load_data, 32'hDEAD_BEEF);
        step();
        check("t2_pulse", {31'b0, bus.out_valid}, 32'd0);

        // Byte store and byte loads with both extensions
        issue(32'h0000_0080, 32'h41, 1'b0, 1'b1, 2'b00, 1'b0);
        wait_result("t3_store", 32'h0000_0080, 1'b0);
        issue(32'h0, 32'h41, 1'b1, 1'b1, 2'b00, 1'b0);
        wait_result("t3_lb", 32'hFFFF_FF80, 1'b0);
        issue(32'h0, 32'h41, 1'b1, 1'b1, 2'b00, 1'b1);
        wait_result("t3_lbu", 32'h0000_0080, 1'b0);
        issue(32'h0, 32'h40, 1'b1, 1'b1, 2'b10, 1'b0);
        wait_result("t3_word", 32'hDEAD_80EF, 1'b0);

        // Half loads
        issue(32'h8001_7FFF, 32'h40, 1'b0, 1'b1, 2'b10, 1'b0);
        wait_result("t4_store", 32'h8001_7FFF, 1'b0);
        issue(32'h0, 32'h42, 1'b1, 1'b1, 2'b01, 1'b0);
        wait_result("t4_lh_hi", 32'hFFFF_8001, 1'b0);
        issue(32'h0, 32'h42, 1'b1, 1'b1, 2'b01, 1'b1);
        wait_result("t4_lhu_hi", 32'h0000_8001, 1'b0);
        issue(32'h0, 32'h40, 1'b1, 1'b1, 2'b01, 1'b0);
        wait_result("t4_lh_lo", 32'h0000_7FFF, 1'b0);

        // Misaligned store and load
        issue(32'h1122_3344, 32'h44, 1'b0, 1'b1, 2'b10, 1'b0);
        wait_result("t5_pre", 32'h1122_3344, 1'b0);
        issue(32'hAAAA_AAAA, 32'h46, 1'b0, 1'b1, 2'b10, 1'b0);
        wait_result("t5_mis_store", 32'hAAAA_AAAA, 1'b1);
        issue(32'h0, 32'h44, 1'b1, 1'b1, 2'b10, 1'b0);
        wait_result("t5_word44", 32'h1122_3344, 1'b0);
        issue(32'h5555_5555, 32'h43, 1'b1, 1'b1, 2'b01, 1'b0);
        check("t5_mis_load_nostall", {31'b0, bus.stall}, 32'd0);
        check("t5_mis_load_lat", {31'b0, bus.out_valid}, 32'd1);
        wait_result("t5_mis_load", 32'h0, 1'b1);
        step();
        check("t5_idle_valid", {31'b0, bus.out_valid}, 32'd0);
        check("t5_idle_hold", bus.load_data, 32'h0);

        // Address aliasing modulo the depth
        issue(32'hCAFE_F00D, 32'h40 + 4*DEPTH, 1'b0, 1'b1, 2'b10, 1'b0);
        wait_result("alias_store", 32'hCAFE_F00D, 1'b0);
        issue(32'h0, 32'h40, 1'b1, 1'b1, 2'b10, 1'b0);
        wait_result("alias_load", 32'hCAFE_F00D, 1'b0);

        // Fill every word so random loads read known data
        for (int w = 0; w < DEPTH; w++) issue($urandom, 32'(4*w), 1'b0, 1'b1, 2'b10, 1'b0);

        // Random ops, often back-to-back behind a waiting load
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            kind = $urandom_range(0, 2);
            rs   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'b01) ra[0] = 1'b0;
                else if (rs[1]) ra[1:0] = 2'b00;
            end
            issue($urandom, ra, kind == 1, kind != 0, rs, 1'($urandom_range(0, 1)));
        end
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Read latency 3: store, full load timing, reset in mid-wait, RAM survives reset
        bus3.mResult = 32'h5555_AAAA; bus3.mAddr = 32'h40; bus3.mAddrEnable = 1'b1;
        bus3.mRdEnable = 1'b0; bus3.mSize = 2'b10; bus3.in_valid = 1'b1;
        step();
        bus3.in_valid = 1'b0;
        check("r3_store_valid", {31'b0, bus3.out_valid}, 32'd1);
        bus3.mRdEnable = 1'b1; bus3.in_valid = 1'b1;
        step();
        bus3.in_valid = 1'b0;
        check("r3_stall_c1", {31'b0, bus3.stall}, 32'd1);
        step();
        check("r3_stall_c2", {31'b0, bus3.stall}, 32'd1);
        step();
        check("r3_stall_c3", {31'b0, bus3.stall}, 32'd0);
        check("r3_valid_c3", {31'b0, bus3.out_valid}, 32'd0);
        step();
        check("r3_valid_c4", {31'b0, bus3.out_valid}, 32'd1);
        check("r3_data_c4", bus3.load_data, 32'h5555_AAAA);
        step();
        bus3.in_valid = 1'b1;
        step();
        bus3.in_valid = 1'b0;
        step();
        check("r3_mid_wait_stall", {31'b0, bus3.stall}, 32'd1);
        rst3 = 1'b1;
        #1;
        check("r3_rst_stall", {31'b0, bus3.stall}, 32'd0);
        check("r3_rst_valid", {31'b0, bus3.out_valid}, 32'd0);
        check("r3_rst_data", bus3.load_data, 32'h0);
        check("r3_rst_state", {31'b0, dbg_state3}, 32'd0);
        step();
        rst3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("r3_no_stale_valid", {31'b0, bus3.out_valid}, 32'd0);
        end
        bus3.in_valid = 1'b1;
        step();
        bus3.in_valid = 1'b0;
        budget = 8;
        while (bus3.out_valid !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        check("r3_ram_kept_valid", {31'b0, bus3.out_valid}, 32'd1);
        check("r3_ram_kept_data", bus3.load_data, 32'h5555_AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
